// File: rtl/fbuf_pkg.sv
// -----------------------------------------------------------------------------
// fbuf_pkg
// Shared definitions for the framebuffer write (command decoder) and read
// (scanout) sides:
//   - default 640x480@60 video timing constants
//   - default framebuffer word/address widths (RGB332 words)
//   - vid_ctl_t: control bits that travel alongside a BRAM read
//   - rgb332_to_rgb888(): bit-replicating colour expansion
// -----------------------------------------------------------------------------
package fbuf_pkg;

  localparam int FBUF_DATA_WIDTH_DEF = 8;
  localparam int FBUF_ADDR_WIDTH_DEF = 19;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Per-pixel control carried through the BRAM latency pipeline.
  typedef struct packed {
    logic de;     // active pixel and scanout enabled for this frame
    logic hs;     // hsync level (polarity already applied)
    logic vs;     // vsync level (polarity already applied)
    logic blank;  // no read was issued for this pixel: force black
    logic first;  // pixel (0,0) of the frame
  } vid_ctl_t;

  // Replicate the top bits of each channel so full-scale maps to 0xFF.
  function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] c);
    return {c[7:5], c[7:5], c[7:6],
            c[4:2], c[4:2], c[4:3],
            c[1:0], c[1:0], c[1:0], c[1:0]};
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Free-running horizontal/vertical raster counters with decoded raw regions.
// Ports:
//   clk, rst      pixel clock, asynchronous active-high reset
//   raw_active    current counter position is a visible pixel
//   raw_hsync     hsync level for the current position (SYNC_POL = asserted)
//   raw_vsync     vsync level for the current position
//   raw_first     current position is (0,0)
//   line_active   current line is a visible line
//   line_wrap     last cycle of a line (h counter wraps on the next edge)
//   frame_wrap    last cycle of the frame (both counters wrap on the next edge)
// -----------------------------------------------------------------------------
module video_timing_gen import fbuf_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  output logic raw_active,
  output logic raw_hsync,
  output logic raw_vsync,
  output logic raw_first,
  output logic line_active,
  output logic line_wrap,
  output logic frame_wrap
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          h_sync_win;
  logic          v_sync_win;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign h_sync_win = (h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                      (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign v_sync_win = (v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                      (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));

  assign line_active = (v_cnt < VW'(V_ACTIVE));
  assign raw_active  = (h_cnt < HW'(H_ACTIVE)) && line_active;
  assign raw_hsync   = h_sync_win ? SYNC_POL : ~SYNC_POL;
  assign raw_vsync   = v_sync_win ? SYNC_POL : ~SYNC_POL;
  assign raw_first   = (h_cnt == '0) && (v_cnt == '0);
  assign line_wrap   = h_last;
  assign frame_wrap  = h_last && v_last;

endmodule

// File: rtl/fbuf_scanout.sv
// -----------------------------------------------------------------------------
// fbuf_scanout
// Reads the framebuffer (BRAM port B) in raster order with optional integer
// pixel replication and emits an aligned hsync/vsync/de/rgb stream.
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   enable          scanout enable, taken once per frame at the frame wrap
//   fbuf_rst_busy   framebuffer clear in progress: suppress reads per pixel
//   fbuf_en_rd      BRAM read enable
//   fbuf_addr       BRAM read address (registered)
//   fbuf_dout       BRAM read data, RGB332, BRAM_LATENCY cycles after address
//   vid_hsync/vsync sync outputs, SYNC_POL = asserted level
//   vid_de          data enable
//   vid_rgb         {R8,G8,B8}, zero whenever vid_de is low
//   frame_start     one-cycle pulse with output pixel (0,0)
// Counter state to vid_* latency is BRAM_LATENCY+1 cycles.
// -----------------------------------------------------------------------------
module fbuf_scanout import fbuf_pkg::*; #(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int H_FP            = H_FP_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BP            = H_BP_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int V_FP            = V_FP_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BP            = V_BP_DEF,
  parameter int SCALE           = 1,
  parameter bit SYNC_POL        = 1'b0,
  parameter int BRAM_LATENCY    = 2,
  parameter int FBUF_ADDR_WIDTH = FBUF_ADDR_WIDTH_DEF,
  parameter int FBUF_DATA_WIDTH = FBUF_DATA_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       fbuf_rst_busy,
  output logic                       fbuf_en_rd,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] fbuf_dout,
  output logic                       vid_hsync,
  output logic                       vid_vsync,
  output logic                       vid_de,
  output logic [23:0]                vid_rgb,
  output logic                       frame_start
);

  localparam int AW         = FBUF_ADDR_WIDTH;
  localparam int LINE_WORDS = H_ACTIVE / SCALE;
  localparam int SW         = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  localparam vid_ctl_t CTL_IDLE = '{de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL,
                                    blank: 1'b1, first: 1'b0};

  logic raw_active, raw_hsync, raw_vsync, raw_first;
  logic line_active, line_wrap, frame_wrap;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk(clk), .rst(rst),
    .raw_active(raw_active), .raw_hsync(raw_hsync), .raw_vsync(raw_vsync),
    .raw_first(raw_first), .line_active(line_active),
    .line_wrap(line_wrap), .frame_wrap(frame_wrap)
  );

  // enable only takes effect at frame boundaries so a frame is never torn.
  logic scan_on;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             scan_on <= 1'b0;
    else if (frame_wrap) scan_on <= enable;
  end

  // Address generator. x_pos/line_base describe the pixel the counters point
  // at now; the *_next values describe the following pixel so that the
  // registered address lines up with the raw active flag.
  logic [SW-1:0] sub_x, sub_y, sub_x_next, sub_y_next;
  logic [AW-1:0] x_pos, line_base, x_next, line_base_next;
  logic [AW-1:0] addr_reg;

  always_comb begin
    sub_x_next     = sub_x;
    sub_y_next     = sub_y;
    x_next         = x_pos;
    line_base_next = line_base;
    if (frame_wrap) begin
      sub_x_next     = '0;
      sub_y_next     = '0;
      x_next         = '0;
      line_base_next = '0;
    end else if (line_wrap) begin
      sub_x_next = '0;
      x_next     = '0;
      if (line_active) begin
        if (sub_y == SUB_LAST) begin
          sub_y_next     = '0;
          line_base_next = line_base + AW'(LINE_WORDS);
        end else begin
          sub_y_next = sub_y + SW'(1);
        end
      end
    end else if (raw_active) begin
      if (sub_x == SUB_LAST) begin
        sub_x_next = '0;
        x_next     = x_pos + AW'(1);
      end else begin
        sub_x_next = sub_x + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_x     <= '0;
      sub_y     <= '0;
      x_pos     <= '0;
      line_base <= '0;
      addr_reg  <= '0;
    end else begin
      sub_x     <= sub_x_next;
      sub_y     <= sub_y_next;
      x_pos     <= x_next;
      line_base <= line_base_next;
      addr_reg  <= line_base_next + x_next;
    end
  end

  assign fbuf_addr  = addr_reg;
  assign fbuf_en_rd = raw_active & scan_on & ~fbuf_rst_busy;

  // Display is blanked (de low) for frames with scanout disabled; a clear in
  // progress keeps de but forces the pixel black through the blank flag.
  vid_ctl_t ctl_in;
  assign ctl_in = '{de: raw_active & scan_on, hs: raw_hsync, vs: raw_vsync,
                    blank: ~fbuf_en_rd, first: raw_first};

  for (genvar gi = 0; gi < BRAM_LATENCY; gi++) begin : g_pipe
    vid_ctl_t d;
    vid_ctl_t q;
    if (gi == 0) begin : g_head
      assign d = ctl_in;
    end else begin : g_tail
      assign d = g_pipe[gi-1].q;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= CTL_IDLE;
      else     q <= d;
    end
  end

  vid_ctl_t ctl_out;
  assign ctl_out = g_pipe[BRAM_LATENCY-1].q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid_hsync   <= ~SYNC_POL;
      vid_vsync   <= ~SYNC_POL;
      vid_de      <= 1'b0;
      vid_rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      vid_hsync   <= ctl_out.hs;
      vid_vsync   <= ctl_out.vs;
      vid_de      <= ctl_out.de;
      frame_start <= ctl_out.first;
      vid_rgb     <= (ctl_out.de && !ctl_out.blank) ?
                     rgb332_to_rgb888(fbuf_dout[7:0]) : 24'h0;
    end
  end

endmodule
